// File: rtl/parity_serializer.sv
// parity_serializer: frames a byte as start, LSB-first data, supplied parity, stop; flags inconsistent parity pairs
module parity_serializer #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PAR_SEL      = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] data_in,
  input  logic              even_parity,
  input  logic              odd_parity,
  output logic              busy,
  output logic              tx_out,
  output logic              done,
  output logic              parity_err
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = DATA_W > 1 ? $clog2(DATA_W) : 1;
  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] sh_next;
  logic              par_bit;
  logic [CW-1:0]     clk_cnt;
  logic [BW-1:0]     bit_cnt;
  logic              bit_end;
  assign bit_end = clk_cnt == CW'(CLKS_PER_BIT - 1);
  // tx_out is registered, so the next data bit is taken from the pre-shifted word
  assign sh_next = shreg >> 1;
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      par_bit    <= 1'b0;
      clk_cnt    <= '0;
      bit_cnt    <= '0;
      busy       <= 1'b0;
      tx_out     <= 1'b1;
      done       <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (load) begin
          shreg      <= data_in;
          par_bit    <= PAR_SEL != 0 ? odd_parity : even_parity;
          parity_err <= (even_parity != ^data_in) | (odd_parity != ~^data_in);
          clk_cnt    <= '0;
          bit_cnt    <= '0;
          busy       <= 1'b1;
          tx_out     <= 1'b0;
          state      <= START;
        end
      end else begin
        clk_cnt <= bit_end ? '0 : clk_cnt + 1'b1;
        if (bit_end) begin
          case (state)
            START: begin
              tx_out <= shreg[0];
              state  <= DATA;
            end
            DATA: begin
              if (bit_cnt == BW'(DATA_W - 1)) begin
                tx_out <= par_bit;
                state  <= PARITY;
              end else begin
                shreg   <= sh_next;
                tx_out  <= sh_next[0];
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
            PARITY: begin
              tx_out <= 1'b1;
              state  <= STOP;
            end
            STOP: begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_parity_serializer.sv
// tb_parity_serializer: directed checks of framing, parity flagging, load gating, back-to-back and reset abort
module tb_parity_serializer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] load_v = 3'b000;
  logic [7:0] data_in = 8'h00;
  logic       even_parity = 1'b0;
  logic       odd_parity = 1'b1;
  logic [2:0] busy_v, tx_v, done_v, err_v;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  parity_serializer #(.DATA_W(8), .CLKS_PER_BIT(4), .PAR_SEL(0)) u0 (
    .clk(clk), .rst(rst), .load(load_v[0]), .data_in(data_in), .even_parity(even_parity),
    .odd_parity(odd_parity), .busy(busy_v[0]), .tx_out(tx_v[0]), .done(done_v[0]), .parity_err(err_v[0]));
  parity_serializer #(.DATA_W(8), .CLKS_PER_BIT(4), .PAR_SEL(1)) u1 (
    .clk(clk), .rst(rst), .load(load_v[1]), .data_in(data_in), .even_parity(even_parity),
    .odd_parity(odd_parity), .busy(busy_v[1]), .tx_out(tx_v[1]), .done(done_v[1]), .parity_err(err_v[1]));
  parity_serializer #(.DATA_W(8), .CLKS_PER_BIT(1), .PAR_SEL(0)) u2 (
    .clk(clk), .rst(rst), .load(load_v[2]), .data_in(data_in), .even_parity(even_parity),
    .odd_parity(odd_parity), .busy(busy_v[2]), .tx_out(tx_v[2]), .done(done_v[2]), .parity_err(err_v[2]));

  // Loads one word into instance s and records mid-bit tx samples, busy cycles and done pulses
  task automatic capture(input int s, input logic [7:0] d, input logic e, input logic o,
                         output logic [10:0] bits, output int busy_n, output int done_n, output logic err0);
    int cpb;
    cpb = (s == 2) ? 1 : 4;
    @(negedge clk);
    data_in = d; even_parity = e; odd_parity = o;
    load_v[s] = 1'b1;
    @(negedge clk);
    load_v = 3'b000;
    err0 = err_v[s];
    busy_n = 0; done_n = 0; bits = 'x;
    for (int j = 0; j < 60; j++) begin
      if (j < 11 * cpb && j % cpb == cpb / 2) bits[j / cpb] = tx_v[s];
      busy_n += int'(busy_v[s]);
      done_n += int'(done_v[s]);
      if (j != 59) @(negedge clk);
    end
  endtask

  task automatic test_reset;
    int bad;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy_v !== 3'b000 || tx_v !== 3'b111 || done_v !== 3'b000 || err_v !== 3'b000) begin
      errors++;
      $display("FAIL reset_state: busy=%b tx=%b done=%b err=%b required 000 111 000 000", busy_v, tx_v, done_v, err_v);
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx_v !== 3'b111) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL idle_tx: %0d cycles with tx low, required 0", bad);
    end
  endtask

  task automatic test_default_frame;
    logic [10:0] bits; int bn, dn; logic e0;
    capture(0, 8'hA5, 1'b0, 1'b1, bits, bn, dn, e0);
    checks++;
    if (bits !== 11'b1_0_10100101_0) begin
      errors++;
      $display("FAIL a5_frame: got %b required %b", bits, 11'b1_0_10100101_0);
    end
    checks++;
    if (bn !== 44 || dn !== 1) begin
      errors++;
      $display("FAIL a5_timing: busy=%0d done=%0d required 44 1", bn, dn);
    end
    checks++;
    if (e0 !== 1'b0) begin
      errors++;
      $display("FAIL a5_err: got %b required 0", e0);
    end
  endtask

  task automatic test_odd_select;
    logic [10:0] bits; int bn, dn; logic e0;
    capture(1, 8'h07, 1'b1, 1'b0, bits, bn, dn, e0);
    checks++;
    if (bits !== 11'b1_0_00000111_0 || e0 !== 1'b0) begin
      errors++;
      $display("FAIL odd_sel_07: frame %b err %b required %b 0", bits, e0, 11'b1_0_00000111_0);
    end
    capture(1, 8'h03, 1'b0, 1'b1, bits, bn, dn, e0);
    checks++;
    if (bits !== 11'b1_1_00000011_0 || e0 !== 1'b0 || bn !== 44) begin
      errors++;
      $display("FAIL odd_sel_03: frame %b err %b busy %0d required %b 0 44", bits, e0, bn, 11'b1_1_00000011_0);
    end
  endtask

  task automatic test_parity_err;
    logic [10:0] bits; int bn, dn; logic e0;
    capture(0, 8'h01, 1'b0, 1'b0, bits, bn, dn, e0);
    checks++;
    if (e0 !== 1'b1 || bits !== 11'b1_0_00000001_0) begin
      errors++;
      $display("FAIL bad_even: err %b frame %b required 1 %b", e0, bits, 11'b1_0_00000001_0);
    end
    checks++;
    if (err_v[0] !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: got %b required 1", err_v[0]);
    end
    capture(0, 8'h01, 1'b1, 1'b0, bits, bn, dn, e0);
    checks++;
    if (e0 !== 1'b0 || bits !== 11'b1_1_00000001_0) begin
      errors++;
      $display("FAIL err_clear: err %b frame %b required 0 %b", e0, bits, 11'b1_1_00000001_0);
    end
    capture(1, 8'h01, 1'b1, 1'b1, bits, bn, dn, e0);
    checks++;
    if (e0 !== 1'b1 || bits !== 11'b1_1_00000001_0) begin
      errors++;
      $display("FAIL bad_odd: err %b frame %b required 1 %b", e0, bits, 11'b1_1_00000001_0);
    end
  endtask

  task automatic test_back_to_back;
    logic [10:0] bits, bits2; int bn, dn;
    @(negedge clk);
    data_in = 8'hA5; even_parity = 1'b0; odd_parity = 1'b1; load_v[0] = 1'b1;
    @(negedge clk);
    load_v = 3'b000;
    bn = 0; dn = 0; bits = 'x;
    for (int j = 0; j < 44; j++) begin
      if (j % 4 == 2) bits[j / 4] = tx_v[0];
      bn += int'(busy_v[0]);
      dn += int'(done_v[0]);
      load_v[0] = (j == 9 || j == 29);
      if (j == 9) begin data_in = 8'hFF; even_parity = 1'b1; odd_parity = 1'b1; end
      @(negedge clk);
    end
    checks++;
    if (bits !== 11'b1_0_10100101_0 || bn !== 44 || dn !== 0) begin
      errors++;
      $display("FAIL ignore_load: frame %b busy %0d early done %0d required %b 44 0", bits, bn, dn, 11'b1_0_10100101_0);
    end
    checks++;
    if (done_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || tx_v[0] !== 1'b1) begin
      errors++;
      $display("FAIL done_cycle: done %b busy %b tx %b required 1 0 1", done_v[0], busy_v[0], tx_v[0]);
    end
    data_in = 8'h3C; even_parity = 1'b0; odd_parity = 1'b1; load_v[0] = 1'b1;
    @(negedge clk);
    load_v = 3'b000;
    checks++;
    if (busy_v[0] !== 1'b1 || tx_v[0] !== 1'b0 || done_v[0] !== 1'b0) begin
      errors++;
      $display("FAIL b2b_start: busy %b tx %b done %b required 1 0 0", busy_v[0], tx_v[0], done_v[0]);
    end
    dn = 0; bits2 = 'x;
    for (int j = 0; j < 50; j++) begin
      if (j < 44 && j % 4 == 2) bits2[j / 4] = tx_v[0];
      dn += int'(done_v[0]);
      @(negedge clk);
    end
    checks++;
    if (bits2 !== 11'b1_0_00111100_0 || dn !== 1) begin
      errors++;
      $display("FAIL b2b_frame: frame %b done %0d required %b 1", bits2, dn, 11'b1_0_00111100_0);
    end
  endtask

  task automatic test_mid_reset;
    logic [10:0] bits; int bn, dn; logic e0;
    @(negedge clk);
    data_in = 8'hA5; even_parity = 1'b0; odd_parity = 1'b1; load_v[0] = 1'b1;
    @(negedge clk);
    load_v = 3'b000;
    repeat (17) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy_v[0] !== 1'b0 || tx_v[0] !== 1'b1 || done_v[0] !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: busy %b tx %b done %b required 0 1 0", busy_v[0], tx_v[0], done_v[0]);
    end
    dn = 0;
    for (int j = 0; j < 40; j++) begin
      dn += int'(done_v[0]) + int'(busy_v[0]);
      @(negedge clk);
    end
    checks++;
    if (dn !== 0) begin
      errors++;
      $display("FAIL abort_quiet: %0d done/busy cycles after abort required 0", dn);
    end
    capture(0, 8'h5A, 1'b0, 1'b1, bits, bn, dn, e0);
    checks++;
    if (bits !== 11'b1_0_01011010_0 || bn !== 44 || dn !== 1) begin
      errors++;
      $display("FAIL after_reset: frame %b busy %0d done %0d required %b 44 1", bits, bn, dn, 11'b1_0_01011010_0);
    end
  endtask

  task automatic test_one_clk_per_bit;
    logic [10:0] bits; int bn, dn; logic e0;
    capture(2, 8'hC3, 1'b0, 1'b1, bits, bn, dn, e0);
    checks++;
    if (bits !== 11'b1_0_11000011_0 || bn !== 11 || dn !== 1) begin
      errors++;
      $display("FAIL cpb1: frame %b busy %0d done %0d required %b 11 1", bits, bn, dn, 11'b1_0_11000011_0);
    end
  endtask

  initial begin
    test_reset;
    test_default_frame;
    test_odd_select;
    test_parity_err;
    test_back_to_back;
    test_mid_reset;
    test_one_clk_per_bit;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
